// File: rtl/reg_window_spill.sv
// Purpose: spill a register window to memory, or fill it back from memory, one register at a time.
// Latency: at least 2 cycles per register (read/write + memory handshake) plus one DONE cycle; outputs are registered.
// Backpressure: cmd_ready is high only when idle; mem_req/mem_addr are held stable until mem_ack is sampled.
module reg_window_spill #(
  parameter int NREG = 4,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [1:0]    cmd_wind,
  input  logic [DW-1:0] cmd_base,
  output logic [1:0]    rf_wind,
  output logic [1:0]    rf_rr,
  input  logic [DW-1:0] rf_rdata,
  output logic [1:0]    rf_wr,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_write,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SPILL_RD  = 3'd1,
    SPILL_REQ = 3'd2,
    FILL_REQ  = 3'd3,
    FILL_WR   = 3'd4,
    DONE      = 3'd5
  } state_t;

  // Index of the final register in the window; the index itself is always 2 bits.
  localparam logic [1:0] LAST_IDX = 2'(NREG - 1);

  // Control state
  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    wind_q, wind_d;
  logic [DW-1:0] base_q, base_d;

  // Data captured mid-transfer, also driven straight out
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;

  // Registered outputs, computed from the next state so they line up with it
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic          rf_write_q, rf_write_d;
  logic [1:0]    rf_wr_q, rf_wr_d;
  logic [1:0]    rf_rr_q, rf_rr_d;
  logic [1:0]    rf_wind_q, rf_wind_d;

  // Next-state, index and data-capture logic for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wind_d      = wind_q;
    base_d      = base_q;
    mem_wdata_d = mem_wdata_q;
    rf_wdata_d  = rf_wdata_q;
    case (state_q)
      IDLE: begin
        // cmd_ready_q is only high in IDLE, and stays low for the first cycle out of reset.
        if (cmd_valid && cmd_ready_q) begin
          wind_d  = cmd_wind;
          base_d  = cmd_base;
          idx_d   = 2'd0;
          state_d = cmd_op ? FILL_REQ : SPILL_RD;
        end
      end
      SPILL_RD: begin
        // rf_rr already points at idx, so the register file data is valid now.
        mem_wdata_d = rf_rdata;
        state_d     = SPILL_REQ;
      end
      SPILL_REQ: begin
        if (mem_ack) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = SPILL_RD;
          end
        end
      end
      FILL_REQ: begin
        if (mem_ack) begin
          rf_wdata_d = mem_rdata;
          state_d    = FILL_WR;
        end
      end
      FILL_WR: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = FILL_REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decode the outputs for the upcoming state so they can be registered with it.
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    mem_req_d   = (state_d == SPILL_REQ) || (state_d == FILL_REQ);
    mem_we_d    = (state_d == SPILL_REQ);
    mem_addr_d  = '0;
    if (mem_req_d) begin
      // Plain DW-bit add, so the address wraps modulo 2^DW.
      mem_addr_d = base_d + {{(DW-2){1'b0}}, idx_d};
    end
    rf_write_d  = (state_d == FILL_WR);
    rf_wr_d     = (state_d == FILL_WR) ? idx_d : 2'd0;
    rf_rr_d     = (state_d == SPILL_RD) ? idx_d : 2'd0;
    rf_wind_d   = busy_d ? wind_d : 2'd0;
  end

  // All state and outputs; a synchronous reset aborts any transfer on the spot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      wind_q      <= 2'd0;
      base_q      <= '0;
      mem_wdata_q <= '0;
      rf_wdata_q  <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      rf_write_q  <= 1'b0;
      rf_wr_q     <= 2'd0;
      rf_rr_q     <= 2'd0;
      rf_wind_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wind_q      <= wind_d;
      base_q      <= base_d;
      mem_wdata_q <= mem_wdata_d;
      rf_wdata_q  <= rf_wdata_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      rf_write_q  <= rf_write_d;
      rf_wr_q     <= rf_wr_d;
      rf_rr_q     <= rf_rr_d;
      rf_wind_q   <= rf_wind_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rf_write  = rf_write_q;
  assign rf_wr     = rf_wr_q;
  assign rf_wdata  = rf_wdata_q;
  assign rf_rr     = rf_rr_q;
  assign rf_wind   = rf_wind_q;

endmodule

// File: tb/tb_reg_window_spill.sv
// Bench for reg_window_spill: register-file and memory models around the engine, scenario tasks run in order.
// Expected transfers are queued when a command is issued and popped as the engine performs them.
// Memory acks are delayed by a per-test count; reset and stray-ack scenarios check the idle outputs.
module tb_reg_window_spill;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [1:0]    cmd_wind;
  logic [DW-1:0] cmd_base;
  logic [1:0]    rf_wind;
  logic [1:0]    rf_rr;
  logic [DW-1:0] rf_rdata;
  logic [1:0]    rf_wr;
  logic [DW-1:0] rf_wdata;
  logic          rf_write;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]    idx;
    logic [DW-1:0] addr;
    logic [DW-1:0] dat;
  } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0] rf_mem [16];
  logic [DW-1:0] fill_data [4];
  int            ack_dly = 0;
  logic          stray_ack = 1'b0;
  int            wait_cnt = 0;

  reg_window_spill #(.NREG(4), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wind(cmd_wind), .cmd_base(cmd_base),
    .rf_wind(rf_wind), .rf_rr(rf_rr), .rf_rdata(rf_rdata),
    .rf_wr(rf_wr), .rf_wdata(rf_wdata), .rf_write(rf_write),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Combinational register file read
  assign rf_rdata = rf_mem[{rf_wind, rf_rr}];

  // Memory responder: ack after ack_dly waiting cycles of mem_req; stray_ack drives ack while no request
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (wait_cnt >= ack_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = fill_data[mem_addr[1:0]];
        wait_cnt  = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack   = stray_ack;
      mem_rdata = 16'hDEAD;
      wait_cnt  = 0;
    end
  end

  // Issue one command, score every transfer against the queue, and check the done timing
  task automatic run_cmd(input string tag, input logic op, input logic [1:0] wind,
                         input logic [DW-1:0] base, input int dly, input int exp_done);
    int n;
    int done_at;
    logic prev_req;
    logic [DW-1:0] prev_addr;
    exp_t e;
    ack_dly = dly;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      e.idx  = 2'(i);
      e.addr = base + 16'(i);
      e.dat  = op ? fill_data[e.addr[1:0]] : rf_mem[{wind, 2'(i)}];
      exp_q.push_back(e);
    end
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_before_accept: got %b want 1", tag, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_wind = wind; cmd_base = base;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1; done_at = 0; prev_req = 1'b0; prev_addr = '0;
    while (done_at == 0 && n <= 200) begin
      n_vec++;
      if ({busy, cmd_ready} !== 2'b10) begin
        n_err++;
        $display("FAIL %s busy_ready cyc %0d: got %b%b want 10", tag, n, busy, cmd_ready);
      end
      if (mem_req) begin
        n_vec++;
        if (mem_we !== ~op || rf_wind !== wind) begin
          n_err++;
          $display("FAIL %s we_wind cyc %0d: got %b/%0d want %b/%0d", tag, n, mem_we, rf_wind, ~op, wind);
        end
        if (prev_req) begin
          n_vec++;
          if (mem_addr !== prev_addr) begin
            n_err++;
            $display("FAIL %s addr_hold cyc %0d: got %h want %h", tag, n, mem_addr, prev_addr);
          end
        end
        if (mem_ack) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s extra_req cyc %0d: got addr %h want none", tag, n, mem_addr);
          end else if (op == 1'b0) begin
            e = exp_q.pop_front();
            if (mem_addr !== e.addr || mem_wdata !== e.dat) begin
              n_err++;
              $display("FAIL %s spill_write: got %h/%h want %h/%h", tag, mem_addr, mem_wdata, e.addr, e.dat);
            end
          end else if (mem_addr !== exp_q[0].addr) begin
            n_err++;
            $display("FAIL %s fill_addr: got %h want %h", tag, mem_addr, exp_q[0].addr);
          end
        end
      end
      if (rf_write) begin
        n_vec++;
        if (op == 1'b0 || exp_q.size() == 0) begin
          n_err++;
          $display("FAIL %s unexpected_rf_write: got rf_wr %0d want none", tag, rf_wr);
        end else begin
          e = exp_q.pop_front();
          if (rf_wr !== e.idx || rf_wdata !== e.dat || rf_wind !== wind) begin
            n_err++;
            $display("FAIL %s rf_write: got %0d/%h/%0d want %0d/%h/%0d", tag, rf_wr, rf_wdata, rf_wind, e.idx, e.dat, wind);
          end
        end
      end
      prev_req  = mem_req && !mem_ack;
      prev_addr = mem_addr;
      if (done === 1'b1) begin
        done_at = n;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    n_vec++;
    if (done_at != exp_done) begin
      n_err++;
      $display("FAIL %s done_cycle: got %0d want %0d", tag, done_at, exp_done);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s missing_transfers: got %0d left want 0", tag, exp_q.size());
    end
    @(negedge clk);
    n_vec++;
    if ({done, busy, cmd_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL %s back_to_idle: got %b%b%b want 001", tag, done, busy, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_wind = 2'd0; cmd_base = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({cmd_ready, busy, done, mem_req, mem_we, rf_write, rf_wind, rf_rr, rf_wr,
           mem_addr, mem_wdata, rf_wdata} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got rdy%b busy%b done%b req%b wr%b addr%h want all 0",
                 cmd_ready, busy, done, mem_req, rf_write, mem_addr);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({cmd_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release: got rdy%b busy%b want rdy1 busy0", cmd_ready, busy);
    end
  endtask

  task automatic test_spill();
    run_cmd("spill_w2", 1'b0, 2'd2, 16'h0100, 0, 9);
  endtask

  task automatic test_fill_delay();
    run_cmd("fill_w1_dly3", 1'b1, 2'd1, 16'h0200, 3, 21);
  endtask

  task automatic test_wrap();
    run_cmd("spill_wrap", 1'b0, 2'd3, 16'hFFFE, 1, 13);
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_spill", 1'b0, 2'd0, 16'h1230, 0, 9);
    run_cmd("b2b_fill", 1'b1, 2'd3, 16'h4444, 0, 9);
  endtask

  task automatic test_busy();
    int first_rdy;
    int done1;
    int done2;
    ack_dly = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_wind = 2'd2; cmd_base = 16'h0300;
    first_rdy = 0; done1 = 0; done2 = 0;
    for (int n = 1; n <= 60 && done2 == 0; n++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1 && first_rdy == 0) first_rdy = n;
      if (done === 1'b1) begin
        if (done1 == 0) done1 = n;
        else done2 = n;
      end
      if (first_rdy != 0 && n == first_rdy + 1) begin
        cmd_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL busy_second_start: got busy %b want 1", busy);
        end
      end
    end
    cmd_valid = 1'b0;
    n_vec++;
    if (done1 != 9 || first_rdy != 10) begin
      n_err++;
      $display("FAIL busy_no_queue: got done %0d ready %0d want 9 10", done1, first_rdy);
    end
    n_vec++;
    if (done2 != 19) begin
      n_err++;
      $display("FAIL busy_second_done: got %0d want 19", done2);
    end
    @(negedge clk);
  endtask

  task automatic test_stray_ack();
    stray_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, done, mem_req, rf_write, cmd_ready} !== 5'b00001 || mem_addr !== '0) begin
        n_err++;
        $display("FAIL stray_ack: got busy%b done%b req%b wr%b rdy%b addr%h want idle",
                 busy, done, mem_req, rf_write, cmd_ready, mem_addr);
      end
    end
    stray_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int abort_at;
    exp_t e;
    ack_dly = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      e.idx  = 2'(i);
      e.addr = 16'h0200 + 16'(i);
      e.dat  = fill_data[i];
      exp_q.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_wind = 2'd1; cmd_base = 16'h0200;
    @(negedge clk);
    cmd_valid = 1'b0;
    abort_at = 0;
    for (int n = 1; n <= 30 && abort_at == 0; n++) begin
      if (rf_write === 1'b1) begin
        e = exp_q.pop_front();
        n_vec++;
        if (rf_wr !== e.idx || rf_wdata !== e.dat) begin
          n_err++;
          $display("FAIL abort_pre_write: got %0d/%h want %0d/%h", rf_wr, rf_wdata, e.idx, e.dat);
        end
        if (rf_wr === 2'd1) begin
          rst = 1'b1;
          abort_at = n;
        end
      end
      if (abort_at == 0) @(negedge clk);
    end
    n_vec++;
    if (abort_at != 4) begin
      n_err++;
      $display("FAIL abort_trigger: got cycle %0d want 4", abort_at);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if ({rf_write, mem_req, done, busy, cmd_ready} !== 5'b00000) begin
        n_err++;
        $display("FAIL abort_quiet: got wr%b req%b done%b busy%b rdy%b want 0",
                 rf_write, mem_req, done, busy, cmd_ready);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1 || exp_q.size() != 2) begin
      n_err++;
      $display("FAIL abort_release: got rdy %b left %0d want rdy 1 left 2", cmd_ready, exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 16'h5000 + 16'(i * 16'h0111);
    rf_mem[8]  = 16'h000A;
    rf_mem[9]  = 16'h000B;
    rf_mem[10] = 16'h000C;
    rf_mem[11] = 16'h000D;
    fill_data[0] = 16'h1111;
    fill_data[1] = 16'h2222;
    fill_data[2] = 16'h3333;
    fill_data[3] = 16'h4444;
    test_reset();
    test_spill();
    test_fill_delay();
    test_wrap();
    test_busy();
    test_back_to_back();
    test_stray_ack();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
